axis_packet_arbiter: RTL

Round-robin AXI-Stream arbiter that shares one processing channel (pipeline plus output FIFO) between `NUM_PORTS` upstream packet sources. It sits directly in front of the channel's slave port and grants the channel to exactly one source per packet. A grant is held from the first beat until the beat carrying `tlast`. The block tags every output beat with the source index and reports packet completions for status and interrupt logic.

---
 rtl/axis_packet_arbiter_if.sv | 28 ++
 rtl/axis_packet_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle between N upstream sources and one shared channel.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface axis_packet_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic                            m_axis_tlast;
  logic [ID_WIDTH-1:0]             m_axis_tid;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter. It grants the shared channel to one source for a whole packet.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no grant; scans requests starting at rr_ptr
//   ST_LOCKED | grant held; datapath follows the granted source until tlast
module axis_packet_arbiter #(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  axis_packet_arbiter_if.slave    bus,
  output logic                    busy,
  output logic                    pkt_done,
  output logic [ID_WIDTH-1:0]     pkt_done_id,
  output logic [15:0]             beat_count
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  localparam logic [ID_WIDTH:0]   NP_W     = (ID_WIDTH+1)'(NUM_PORTS);
  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_PORTS - 1);

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [15:0]         beat_cnt_q, beat_cnt_d;
  logic                pkt_done_q, pkt_done_d;
  logic [ID_WIDTH-1:0] pkt_done_id_q, pkt_done_id_d;

  logic                  locked;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  hs;
  logic [15:0]           beat_live;

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  logic                   found;
  logic [ID_WIDTH-1:0]    off;
  logic [ID_WIDTH:0]      sum;
  logic [ID_WIDTH-1:0]    pick;

  assign locked = (state_q == ST_LOCKED);

  // Select the granted source and drive the channel and the per-source readies.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    bus.s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_data  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = bus.s_axis_tvalid[i];
        sel_last  = bus.s_axis_tlast[i];
        bus.s_axis_tready[i] = locked & bus.m_axis_tready;
      end
    end
    bus.m_axis_tdata  = sel_data;
    bus.m_axis_tvalid = locked & sel_valid;
    bus.m_axis_tlast  = locked & sel_last;
    bus.m_axis_tid    = grant_q;
  end

  // Rotate the requests so that bit 0 is rr_ptr, then take the lowest set bit.
  always_comb begin
    req_dbl = {bus.s_axis_tvalid, bus.s_axis_tvalid} >> rr_ptr_q;
    req_rot = req_dbl[NUM_PORTS-1:0];
    found   = 1'b0;
    off     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found = 1'b1;
        off   = ID_WIDTH'(k);
      end
    end
    sum  = {1'b0, rr_ptr_q} + {1'b0, off};
    pick = (sum >= NP_W) ? ID_WIDTH'(sum - NP_W) : sum[ID_WIDTH-1:0];
  end

  // Live beat count includes the handshake completing this cycle and saturates at all-ones.
  always_comb begin
    hs        = bus.m_axis_tvalid & bus.m_axis_tready;
    beat_live = beat_cnt_q;
    if (hs && (beat_cnt_q != 16'hFFFF)) beat_live = beat_cnt_q + 16'd1;
  end

  // Next-state logic: take a grant in IDLE, release it on the tlast handshake.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_live;
    pkt_done_d    = 1'b0;
    pkt_done_id_d = pkt_done_id_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (hs && bus.m_axis_tlast) begin
          state_d       = ST_IDLE;
          rr_ptr_d      = (grant_q == LAST_IDX) ? '0 : grant_q + ID_WIDTH'(1);
          pkt_done_d    = 1'b1;
          pkt_done_id_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register. Reset takes priority over a tlast handshake in the same cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      beat_cnt_q    <= '0;
      pkt_done_q    <= 1'b0;
      pkt_done_id_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      beat_cnt_q    <= beat_cnt_d;
      pkt_done_q    <= pkt_done_d;
      pkt_done_id_q <= pkt_done_id_d;
    end
  end

  assign busy        = locked;
  assign pkt_done    = pkt_done_q;
  assign pkt_done_id = pkt_done_id_q;
  assign beat_count  = beat_live;

endmodule
